// File: rtl/mux_pkg.sv
// Shared definitions for the registered 4:1 multiplexer: select codes and
// the select type used by the combinational core and the registered top.
package mux_pkg;

  // Select encodings; sel[0] is the LSB.
  localparam logic [1:0] SEL_A = 2'b00;
  localparam logic [1:0] SEL_B = 2'b01;
  localparam logic [1:0] SEL_C = 2'b10;
  localparam logic [1:0] SEL_D = 2'b11;

  typedef logic [1:0] sel_t;

endpackage : mux_pkg

// File: rtl/mux4_comb.sv
// Purely combinational 4:1 select. Output y follows a/b/c/d as chosen by sel.
// It has no state; the registered wrapper samples y on the clock edge.
import mux_pkg::*;

module mux4_comb #(
  parameter int WIDTH = 1
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  input  sel_t             sel,
  output logic [WIDTH-1:0] y
);

  // Decode sel into one of the four data inputs.
  always_comb begin
    // NOTE: default assignment first so every path drives y and no latch is inferred.
    y = '0;
    case (sel)
      SEL_A:   y = a;
      SEL_B:   y = b;
      SEL_C:   y = c;
      SEL_D:   y = d;
      default: y = '0; // X/Z select: value unspecified, zero keeps it benign
    endcase
  end

endmodule : mux4_comb

// File: rtl/mux_4_to_1.sv
// Registered 4-to-1 multiplexer. M takes the selected input one clock edge
// after sel/data are sampled; reset (rst, async, active-high) forces
// RESET_VAL truncated or zero-extended to WIDTH.
// Optional build macro MUX4_PARITY_EN adds a registered even-parity output
// par that tracks the value loaded into M on the same edge.
import mux_pkg::*;

module mux_4_to_1 #(
  parameter int          WIDTH     = 1,
  parameter logic [63:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  output logic [WIDTH-1:0] M,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  input  sel_t             sel
`ifdef MUX4_PARITY_EN
  ,
  output logic             par
`endif
);

  // Reset value fitted to the data width (upper bits dropped, or zero-filled).
  localparam logic [WIDTH-1:0] RST_M = RESET_VAL[WIDTH-1:0];

  logic [WIDTH-1:0] sel_data;

  mux4_comb #(
    .WIDTH (WIDTH)
  ) u_mux4_comb (
    .a   (a),
    .b   (b),
    .c   (c),
    .d   (d),
    .sel (sel),
    .y   (sel_data)
  );

  // Output register: async reset to RST_M, otherwise load the selection every cycle.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: non-blocking assignment for all clocked state avoids simulation races.
    if (rst) begin
      M <= RST_M;
    end else begin
      M <= sel_data;
    end
  end

`ifdef MUX4_PARITY_EN
  // Parity register: even parity of the value loaded into M, same edge and reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par <= ^RST_M;
    end else begin
      par <= ^sel_data;
    end
  end
`endif

  // The select must be known whenever the mux is out of reset.
  sel_known_a : assert property (@(posedge clk) disable iff (rst) !$isunknown(sel));

endmodule : mux_4_to_1

// File: tb/tb_mux_4_to_1.sv
// Self-checking bench for mux_4_to_1: three instances (WIDTH 1, 8, and 4 with
// a truncated non-zero reset value) share clk, rst and sel.
module tb_mux_4_to_1;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] sel;

  logic       a1, b1, c1, d1, m1;
  logic [7:0] a8, b8, c8, d8, m8;
  logic [3:0] a4, b4, c4, d4, m4;
`ifdef MUX4_PARITY_EN
  logic       p1, p8, p4;
`endif

  int errors = 0;
  int checks = 0;

  localparam logic [3:0] RST4 = 4'h7; // low nibble of 64'h1A7

  always #5 clk = ~clk;

  mux_4_to_1 #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .M(m1), .a(a1), .b(b1), .c(c1), .d(d1), .sel(sel)
`ifdef MUX4_PARITY_EN
    , .par(p1)
`endif
  );

  mux_4_to_1 #(.WIDTH(8), .RESET_VAL(64'h00)) dut8 (
    .clk(clk), .rst(rst), .M(m8), .a(a8), .b(b8), .c(c8), .d(d8), .sel(sel)
`ifdef MUX4_PARITY_EN
    , .par(p8)
`endif
  );

  mux_4_to_1 #(.WIDTH(4), .RESET_VAL(64'h1A7)) dut4 (
    .clk(clk), .rst(rst), .M(m4), .a(a4), .b(b4), .c(c4), .d(d4), .sel(sel)
`ifdef MUX4_PARITY_EN
    , .par(p4)
`endif
  );

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    sel = 2'b11;
    {a1, b1, c1, d1} = 4'b1111;
    {a8, b8, c8, d8} = {8'h11, 8'h22, 8'h33, 8'h44};
    {a4, b4, c4, d4} = {4'h1, 4'h2, 4'h3, 4'h9};
    #1; // no clock edge yet
    checks++; if (m1 !== 1'b0) begin errors++; $display("FAIL reset_m1 got=%b exp=0", m1); end
    checks++; if (m8 !== 8'h00) begin errors++; $display("FAIL reset_m8 got=%h exp=00", m8); end
    checks++; if (m4 !== RST4) begin errors++; $display("FAIL reset_m4_trunc got=%h exp=%h", m4, RST4); end
`ifdef MUX4_PARITY_EN
    checks++; if (p4 !== ^RST4) begin errors++; $display("FAIL reset_par4 got=%b exp=%b", p4, ^RST4); end
    checks++; if (p8 !== 1'b0) begin errors++; $display("FAIL reset_par8 got=%b exp=0", p8); end
`endif
    // Held across edges while asserted.
    step();
    checks++; if (m4 !== RST4) begin errors++; $display("FAIL reset_hold_m4 got=%h exp=%h", m4, RST4); end
    rst = 1'b0;
    step();
    checks++; if (m1 !== 1'b1) begin errors++; $display("FAIL reset_release_m1 got=%b exp=1", m1); end
    checks++; if (m4 !== 4'h9) begin errors++; $display("FAIL reset_release_m4 got=%h exp=9", m4); end
  endtask

  task automatic test_onehot_walk();
    for (int s = 0; s < 4; s++) begin
      for (int h = 0; h < 4; h++) begin
        logic [3:0] oh;
        logic       exp;
        oh  = 4'b1000 >> h; // {a,b,c,d}, a hot first
        sel = s[1:0];
        {a1, b1, c1, d1} = oh;
        exp = (h == s);
        step();
        checks++;
        if (m1 !== exp) begin
          errors++;
          $display("FAIL onehot sel=%0d hot=%0d got=%b exp=%b", s, h, m1, exp);
        end
      end
    end
  endtask

  task automatic test_latency();
    logic [7:0] want [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    {a8, b8, c8, d8} = {8'h11, 8'h22, 8'h33, 8'h44};
    for (int s = 0; s < 4; s++) begin
      sel = s[1:0];
      #3; // M still shows previous selection before the edge
      if (s > 0) begin
        checks++;
        if (m8 !== want[s-1]) begin errors++; $display("FAIL latency_pre s=%0d got=%h exp=%h", s, m8, want[s-1]); end
      end
      step();
      checks++;
      if (m8 !== want[s]) begin errors++; $display("FAIL latency s=%0d got=%h exp=%h", s, m8, want[s]); end
    end
  endtask

  task automatic test_async_midstream();
    // Entry: just after an edge, M8 = 8'h44.
    #2;
    rst = 1'b1;
    #1;
    checks++; if (m8 !== 8'h00) begin errors++; $display("FAIL async_rst_m8 got=%h exp=00", m8); end
    checks++; if (m4 !== RST4) begin errors++; $display("FAIL async_rst_m4 got=%h exp=%h", m4, RST4); end
    sel = 2'b10;
    #1;
    rst = 1'b0;
    step();
    checks++; if (m8 !== 8'h33) begin errors++; $display("FAIL async_release_m8 got=%h exp=33", m8); end
  endtask

`ifdef MUX4_PARITY_EN
  task automatic test_parity();
    sel = 2'b00;
    a8  = 8'h07;
    step();
    checks++; if (m8 !== 8'h07) begin errors++; $display("FAIL par_m8_07 got=%h exp=07", m8); end
    checks++; if (p8 !== 1'b1) begin errors++; $display("FAIL par_07 got=%b exp=1", p8); end
    a8 = 8'h03;
    step();
    checks++; if (p8 !== 1'b0) begin errors++; $display("FAIL par_03 got=%b exp=0", p8); end
  endtask
`endif

  // Random select/data against a lookup model: expected = data[sel].
  task automatic test_random();
    for (int n = 0; n < 200; n++) begin
      logic [7:0] d8v [4];
      logic [3:0] d4v [4];
      logic       d1v [4];
      int         s;
      s = $urandom_range(3);
      for (int k = 0; k < 4; k++) begin
        d8v[k] = 8'($urandom);
        d4v[k] = 4'($urandom);
        d1v[k] = 1'($urandom);
      end
      sel = s[1:0];
      {a8, b8, c8, d8} = {d8v[0], d8v[1], d8v[2], d8v[3]};
      {a4, b4, c4, d4} = {d4v[0], d4v[1], d4v[2], d4v[3]};
      {a1, b1, c1, d1} = {d1v[0], d1v[1], d1v[2], d1v[3]};
      step();
      checks++;
      if (m8 !== d8v[s] || m4 !== d4v[s] || m1 !== d1v[s]) begin
        errors++;
        $display("FAIL random n=%0d sel=%0d got=%h/%h/%b exp=%h/%h/%b",
                 n, s, m8, m4, m1, d8v[s], d4v[s], d1v[s]);
      end
`ifdef MUX4_PARITY_EN
      checks++;
      if (p8 !== ^d8v[s] || p4 !== ^d4v[s] || p1 !== d1v[s]) begin
        errors++;
        $display("FAIL random_par n=%0d got=%b%b%b exp=%b%b%b",
                 n, p8, p4, p1, ^d8v[s], ^d4v[s], d1v[s]);
      end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_onehot_walk();
    test_latency();
    test_async_midstream();
`ifdef MUX4_PARITY_EN
    test_parity();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_mux_4_to_1
